// File: rtl/stim_seq_pkg.sv
// Shared types and helpers for the stimulus sequencer.
// Holds the drive-code encoding, the FSM state type and the per-bit code apply.
package stim_seq_pkg;

    localparam logic [1:0] CODE_0    = 2'b00;
    localparam logic [1:0] CODE_1    = 2'b01;
    localparam logic [1:0] CODE_HOLD = 2'b10;
    localparam logic [1:0] CODE_TOG  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        PLAY,
        FIN
    } state_e;

    function automatic logic apply_code(
        input logic [1:0] code,
        input logic       prev
    );
        logic r;
        r = prev;
        case (code)
            CODE_0:    r = 1'b0;
            CODE_1:    r = 1'b1;
            CODE_HOLD: r = prev;
            CODE_TOG:  r = ~prev;
            default:   r = prev;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/stim_seq_mem.sv
// Pattern store: one write port, one registered read port.
// A same-cycle write to the read address is forwarded to the read data.
module stim_seq_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 6,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_d;
    logic [W-1:0] rdata_q;

    always_comb begin
        rdata_d = mem_q[raddr];
        if (we && (waddr == raddr)) begin
            rdata_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/stim_seq.sv
// Stimulus sequencer: plays stored per-channel drive codes onto DOUT
// after a lead-in, one step every STEP_CYC clocks, one-shot or looping.
module stim_seq
    import stim_seq_pkg::*;
#(
    parameter int             NCH      = 3,
    parameter int             DEPTH    = 16,
    parameter int             STEP_CYC = 1000,
    parameter int             LEAD_CYC = 10000,
    parameter logic [NCH-1:0] RST_VAL  = '0,
    localparam int            AW       = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WE,
    input  logic [AW-1:0]    WADDR,
    input  logic [2*NCH-1:0] WDATA,
    input  logic [AW:0]      LEN,
    input  logic             LOOP,
    input  logic             START,
    input  logic             STOP,
    output logic [NCH-1:0]   DOUT,
    output logic             BUSY,
    output logic             DONE,
    output logic [AW-1:0]    STEP
);

    localparam int LW = (LEAD_CYC > 0) ? $clog2(LEAD_CYC + 1) : 1;
    localparam int CW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;

    state_e           state_q, state_d;
    logic [LW-1:0]    lead_q, lead_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [AW-1:0]    step_q, step_d;
    logic [AW-1:0]    nxt_q, nxt_d;
    logic [AW:0]      len_q, len_d;
    logic             loop_q, loop_d;
    logic [NCH-1:0]   dout_q, dout_d;
    logic [2*NCH-1:0] rdata;
    logic [AW:0]      len_in;
    logic [AW:0]      nxt_inc;
    logic             last;
    logic             apply;

    // nxt_q always names the step held in rdata, ready for the next apply
    stim_seq_mem #(
        .DEPTH (DEPTH),
        .W     (2 * NCH),
        .AW    (AW)
    ) u_mem (
        .clk   (CLK),
        .we    (WE),
        .waddr (WADDR),
        .wdata (WDATA),
        .raddr (nxt_d),
        .rdata (rdata)
    );

    assign len_in = ((LEN == '0) || (LEN > (AW+1)'(DEPTH)))
                  ? (AW+1)'(DEPTH) : LEN;
    assign nxt_inc = (AW+1)'(nxt_q) + (AW+1)'(1);
    assign last = (((AW+1)'(step_q) + (AW+1)'(1)) == len_q);

    always_comb begin
        state_d = state_q;
        lead_d  = lead_q;
        cyc_d   = cyc_q;
        step_d  = step_q;
        nxt_d   = nxt_q;
        len_d   = len_q;
        loop_d  = loop_q;
        dout_d  = dout_q;
        apply   = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    len_d  = len_in;
                    loop_d = LOOP;
                    lead_d = '0;
                    cyc_d  = '0;
                    step_d = '0;
                    if (LEAD_CYC == 0) begin
                        state_d = PLAY;
                        apply   = 1'b1;
                    end else begin
                        state_d = LEAD;
                    end
                end
            end
            LEAD: begin
                if (STOP) begin
                    state_d = IDLE;
                end else if (lead_q == LW'(LEAD_CYC - 1)) begin
                    state_d = PLAY;
                    apply   = 1'b1;
                end else begin
                    lead_d = lead_q + LW'(1);
                end
            end
            PLAY: begin
                if (STOP) begin
                    state_d = IDLE;
                end else if (cyc_q == CW'(STEP_CYC - 1)) begin
                    if (last && !loop_q) begin
                        state_d = FIN;
                    end else begin
                        apply = 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (apply) begin
            for (int c = 0; c < NCH; c++) begin
                dout_d[c] = apply_code(rdata[2*c +: 2], dout_q[c]);
            end
            step_d = nxt_q;
            cyc_d  = '0;
            nxt_d  = (nxt_inc == len_d) ? '0 : nxt_inc[AW-1:0];
        end
        // Outside a run, keep step 0 prefetched for a zero-lead start
        if ((state_d == IDLE) || (state_d == FIN)) begin
            nxt_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            lead_q  <= '0;
            cyc_q   <= '0;
            step_q  <= '0;
            nxt_q   <= '0;
            len_q   <= (AW+1)'(DEPTH);
            loop_q  <= 1'b0;
            dout_q  <= RST_VAL;
        end else begin
            state_q <= state_d;
            lead_q  <= lead_d;
            cyc_q   <= cyc_d;
            step_q  <= step_d;
            nxt_q   <= nxt_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            dout_q  <= dout_d;
        end
    end

    assign DOUT = dout_q;
    assign BUSY = (state_q == LEAD) || (state_q == PLAY);
    assign DONE = (state_q == FIN);
    assign STEP = step_q;

endmodule

// File: tb/tb_stim_seq.sv
// Scoreboard bench for stim_seq: two instances (long lead/slow steps and
// zero lead/single-cycle steps) share stimulus and are checked per cycle.
`timescale 1ns/1ps
module tb_stim_seq;

    localparam int DEPTH = 16;

    typedef struct {
        int         idx;
        logic [2:0] dout;
        logic       busy;
        logic       done;
        logic [3:0] step;
        bit         chk_step;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       we    = 1'b0;
    logic [3:0] waddr = '0;
    logic [5:0] wdata = '0;
    logic [4:0] len   = '0;
    logic       loop  = 1'b0;
    logic       start = 1'b0;
    logic       stop  = 1'b0;

    logic [2:0] dout_w [2];
    logic       busy_w [2];
    logic       done_w [2];
    logic [3:0] step_w [2];

    int checks   = 0;
    int failures = 0;

    exp_t       sb[$];
    logic [5:0] mm [DEPTH];

    int         lead_c [2] = '{10, 0};
    int         step_c [2] = '{4, 1};
    logic [2:0] rstv   [2] = '{3'b101, 3'b000};

    bit         m_run  [2];
    bit         m_fin  [2];
    bit         m_loop [2];
    int         m_r    [2];
    int         m_len  [2];
    int         m_step [2];
    logic [2:0] m_dout [2];

    always #5 clk = ~clk;

    stim_seq #(
        .NCH(3), .DEPTH(DEPTH), .STEP_CYC(4),
        .LEAD_CYC(10), .RST_VAL(3'b101)
    ) u0 (
        .CLK(clk), .RST(rst), .WE(we), .WADDR(waddr),
        .WDATA(wdata), .LEN(len), .LOOP(loop),
        .START(start), .STOP(stop), .DOUT(dout_w[0]),
        .BUSY(busy_w[0]), .DONE(done_w[0]), .STEP(step_w[0])
    );

    stim_seq #(
        .NCH(3), .DEPTH(DEPTH), .STEP_CYC(1),
        .LEAD_CYC(0), .RST_VAL(3'b000)
    ) u1 (
        .CLK(clk), .RST(rst), .WE(we), .WADDR(waddr),
        .WDATA(wdata), .LEN(len), .LOOP(loop),
        .START(start), .STOP(stop), .DOUT(dout_w[1]),
        .BUSY(busy_w[1]), .DONE(done_w[1]), .STEP(step_w[1])
    );

    function automatic logic [2:0] play(
        input logic [5:0] w,
        input logic [2:0] prev
    );
        logic [2:0] r;
        for (int c = 0; c < 3; c++) begin
            case (w[2*c +: 2])
                2'd0:    r[c] = 1'b0;
                2'd1:    r[c] = 1'b1;
                2'd2:    r[c] = prev[c];
                default: r[c] = ~prev[c];
            endcase
        end
        return r;
    endfunction

    task automatic chk(
        input string       nm,
        input int          i,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s u%0d: got %0h want %0h at %0t",
                     nm, i, act, exp, $time);
        end
    endtask

    // Reference model: run timeline from cycle offsets since START
    always @(posedge clk) begin
        bit f;
        int p;
        int k;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_run[i]  = 0;
                m_fin[i]  = 0;
                m_step[i] = 0;
                m_dout[i] = rstv[i];
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                f = 0;
                if (m_run[i]) begin
                    if (stop) begin
                        m_run[i] = 0;
                    end else begin
                        m_r[i]++;
                        p = m_r[i] - lead_c[i];
                        if (p >= 0 && (p % step_c[i]) == 0) begin
                            k = p / step_c[i];
                            if (!m_loop[i] && k == m_len[i]) begin
                                m_run[i] = 0;
                                f = 1;
                            end else begin
                                m_dout[i] = play(mm[k % m_len[i]],
                                                 m_dout[i]);
                                m_step[i] = k % m_len[i];
                            end
                        end
                    end
                end else if (start && !m_fin[i]) begin
                    m_run[i]  = 1;
                    m_r[i]    = 0;
                    m_len[i]  = (len == 0 || len > DEPTH) ? DEPTH
                                                          : int'(len);
                    m_loop[i] = loop;
                    if (lead_c[i] == 0) begin
                        m_dout[i] = play(mm[0], m_dout[i]);
                        m_step[i] = 0;
                    end
                end
                m_fin[i] = f;
                sb.push_back('{i, m_dout[i], m_run[i], f,
                               4'(m_step[i]),
                               m_run[i] && m_r[i] >= lead_c[i]});
            end
            if (we) mm[waddr] = wdata;
        end
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            for (int i = 0; i < 2; i++) begin
                chk("rst dout", i, 32'(dout_w[i]), 32'(rstv[i]));
                chk("rst busy", i, 32'(busy_w[i]), 32'd0);
                chk("rst done", i, 32'(done_w[i]), 32'd0);
                chk("rst step", i, 32'(step_w[i]), 32'd0);
            end
        end else begin
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk("dout", e.idx, 32'(dout_w[e.idx]), 32'(e.dout));
                chk("busy", e.idx, 32'(busy_w[e.idx]), 32'(e.busy));
                chk("done", e.idx, 32'(done_w[e.idx]), 32'(e.done));
                if (e.chk_step) begin
                    chk("step", e.idx, 32'(step_w[e.idx]),
                        32'(e.step));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input int a, input logic [5:0] d);
        we    = 1'b1;
        waddr = 4'(a);
        wdata = d;
        tick();
        we    = 1'b0;
    endtask

    task automatic run(input int l, input logic lp);
        len   = 5'(l);
        loop  = lp;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        start = 1'b0;
        stop  = 1'b0;
        we    = 1'b0;
        rst   = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("async dout", i, 32'(dout_w[i]), 32'(rstv[i]));
            chk("async busy", i, 32'(busy_w[i]), 32'd0);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();
        tick();
        wr(0, 6'b000010);
        wr(1, 6'b010001);
        wr(2, 6'b000000);
        for (int a = 3; a < DEPTH; a++) wr(a, 6'($urandom));
        run(3, 1'b0);
        repeat (40) tick();
        run(3, 1'b1);
        repeat (30) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (5) tick();
        for (int a = 0; a < DEPTH; a++) wr(a, 6'b111111);
        run(0, 1'b0);
        repeat (80) tick();
        len   = 5'd3;
        loop  = 1'b0;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        repeat (25) tick();
        run(4, 1'b0);
        repeat (15) tick();
        do_reset();
        run(4, 1'b0);
        repeat (40) tick();
        repeat (4000) begin
            we    = ($urandom % 4) == 0;
            waddr = 4'($urandom);
            wdata = 6'($urandom);
            start = ($urandom % 16) == 0;
            len   = 5'($urandom);
            loop  = ($urandom % 4) == 0;
            stop  = ($urandom % 50) == 0;
            tick();
            if (($urandom % 600) == 0) do_reset();
        end
        we    = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        repeat (5) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
